// File: rtl/channel_sampler_n.sv
// Multi-channel sampler: synchronizes asynchronous inputs, decimates a sample
// strobe, packs DEPTH samples per output word, and detects edges on one channel.
module channel_sampler_n #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2,
    localparam int TSW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         ch_in,
    input  logic                   smpl_en,
    input  logic [7:0]             decim,
    input  logic                   trig_en,
    input  logic [TSW-1:0]         trig_sel,
    input  logic                   trig_pol,
    input  logic                   smpl_rdy,
    input  logic                   clr_ovr,
    output logic [NCH-1:0]         ch_sync,
    output logic [NCH*DEPTH-1:0]   smpl,
    output logic                   smpl_vld,
    output logic                   trig,
    output logic                   ovr
);

    logic [SYNC-1:0][NCH-1:0]  sync_reg;
    logic [7:0]                dec_cnt_reg;
    logic [DEPTH-1:0][NCH-1:0] hist_reg;
    logic [DEPTH-1:0][NCH-1:0] hist_next;
    logic [CW-1:0]             wcnt_reg;
    logic [NCH-1:0]            prev_reg;
    logic                      prev_vld_reg;
    logic [NCH*DEPTH-1:0]      smpl_reg;
    logic                      smpl_vld_reg;
    logic                      trig_reg;
    logic                      ovr_reg;

    logic accept;
    logic word_done;
    logic overrun;
    logic load;
    logic cur_bit;
    logic prev_bit;
    logic sel_ok;
    logic trig_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC-2:0], ch_in};
        end
    end

    assign ch_sync = sync_reg[SYNC-1];

    assign accept    = smpl_en && (dec_cnt_reg == 8'd0);
    assign word_done = accept && (wcnt_reg == CW'(DEPTH - 1));
    assign overrun   = word_done && smpl_vld_reg && !smpl_rdy;
    assign load      = word_done && !overrun;

    // Newest sample enters the top slot, so the packed view is {newest..oldest}.
    assign hist_next = {ch_sync, hist_reg[DEPTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt_reg <= 8'd0;
        end else if (smpl_en) begin
            dec_cnt_reg <= accept ? decim : dec_cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_reg     <= '0;
            wcnt_reg     <= '0;
            prev_reg     <= '0;
            prev_vld_reg <= 1'b0;
        end else if (accept) begin
            hist_reg     <= hist_next;
            wcnt_reg     <= word_done ? '0 : wcnt_reg + CW'(1);
            prev_reg     <= ch_sync;
            prev_vld_reg <= 1'b1;
        end
    end

    // Channel mux written as a compare loop so an unused trig_sel code selects nothing.
    always_comb begin
        cur_bit  = 1'b0;
        prev_bit = 1'b0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (trig_sel == TSW'(i)) begin
                cur_bit  = ch_sync[i];
                prev_bit = prev_reg[i];
                sel_ok   = 1'b1;
            end
        end
    end

    assign trig_hit = accept && trig_en && prev_vld_reg && sel_ok &&
                      (trig_pol ? (!prev_bit && cur_bit) : (prev_bit && !cur_bit));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smpl_reg     <= '0;
            smpl_vld_reg <= 1'b0;
            trig_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            if (load) begin
                smpl_reg     <= hist_next;
                smpl_vld_reg <= 1'b1;
            end else if (smpl_vld_reg && smpl_rdy) begin
                smpl_vld_reg <= 1'b0;
            end

            // A fresh overrun wins over a simultaneous clear.
            if (overrun) begin
                ovr_reg <= 1'b1;
            end else if (clr_ovr) begin
                ovr_reg <= 1'b0;
            end

            trig_reg <= trig_hit;
        end
    end

    assign smpl     = smpl_reg;
    assign smpl_vld = smpl_vld_reg;
    assign trig     = trig_reg;
    assign ovr      = ovr_reg;

endmodule

// File: tb/tb_channel_sampler_n.sv
// Directed bench for channel_sampler_n: a queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_channel_sampler_n;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int W     = NCH * DEPTH;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_in;
    logic           smpl_en;
    logic [7:0]     decim;
    logic           trig_en;
    logic [0:0]     trig_sel;
    logic           trig_pol;
    logic           smpl_rdy;
    logic           clr_ovr;
    logic [NCH-1:0] ch_sync;
    logic [W-1:0]   smpl;
    logic           smpl_vld;
    logic           trig;
    logic           ovr;

    int checks   = 0;
    int failures = 0;
    int word_cnt = 0;
    int w0;

    channel_sampler_n #(.NCH(NCH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .smpl_en(smpl_en), .decim(decim),
        .trig_en(trig_en), .trig_sel(trig_sel), .trig_pol(trig_pol),
        .smpl_rdy(smpl_rdy), .clr_ovr(clr_ovr), .ch_sync(ch_sync), .smpl(smpl),
        .smpl_vld(smpl_vld), .trig(trig), .ovr(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync is a delay line of captured inputs, acceptance is "skipped
    // enough strobes since the last accept", words are queues of accepted samples.
    logic [NCH-1:0] m_pipe[$];
    logic [NCH-1:0] m_samples[$];
    logic [W-1:0]   m_smpl;
    logic [NCH-1:0] m_prev;
    logic           m_vld, m_trig, m_ovr, m_have_prev, m_seen;
    int             m_skipped, m_reload;
    bit             model_ok = 1'b0;

    task automatic model_step();
        logic [NCH-1:0] cur;
        logic [W-1:0]   word;
        logic acc, done, ov, loaded, hit;
        if (!rst_n) begin
            m_pipe = {};
            for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
            m_samples = {};
            m_smpl = '0; m_prev = '0;
            m_vld = 0; m_trig = 0; m_ovr = 0; m_have_prev = 0; m_seen = 0;
            m_skipped = 0; m_reload = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            cur = m_pipe[0];
            word = '0;
            hit = 0; done = 0; ov = 0; loaded = 0;
            acc = smpl_en && (!m_seen || m_skipped >= m_reload);
            if (smpl_en && !acc) m_skipped++;
            if (acc) begin
                m_seen = 1; m_skipped = 0; m_reload = int'(decim);
                if (trig_en && m_have_prev)
                    hit = trig_pol ? (!m_prev[trig_sel] && cur[trig_sel])
                                   : (m_prev[trig_sel] && !cur[trig_sel]);
                m_prev = cur; m_have_prev = 1;
                m_samples.push_back(cur);
                if (m_samples.size() == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) word[i*NCH +: NCH] = m_samples[i];
                    m_samples = {};
                    done = 1;
                end
            end
            if (done && m_vld && !smpl_rdy) ov = 1;
            else if (done) begin m_smpl = word; loaded = 1; end
            if (loaded) m_vld = 1;
            else if (m_vld && smpl_rdy) m_vld = 0;
            if (ov) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
            m_trig = hit;
            m_pipe.push_back(ch_in);
            void'(m_pipe.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("m_ch_sync", ch_sync, m_pipe[0]);
            chk("m_smpl", smpl, m_smpl);
            chk("m_smpl_vld", smpl_vld, m_vld);
            chk("m_trig", trig, m_trig);
            chk("m_ovr", ovr, m_ovr);
        end
    end

    logic vld_d = 1'b0;
    initial forever begin
        @(negedge clk);
        if (smpl_vld && !vld_d) word_cnt++;
        vld_d = smpl_vld;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic strobe();
        @(negedge clk); smpl_en = 1'b1;
        @(negedge clk); smpl_en = 1'b0;
    endtask

    task automatic set_ch(input logic [NCH-1:0] v);
        @(negedge clk); ch_in = v;
        repeat (SYNC + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 0; ch_in = '0; smpl_en = 0; decim = 8'd0; trig_en = 0;
        trig_sel = '0; trig_pol = 1; smpl_rdy = 0; clr_ovr = 0;
        repeat (3) @(negedge clk);
        chk("rst_smpl", smpl, 0);
        chk("rst_vld", smpl_vld, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1;

        // Steady 2'b10 -> 8'hAA, valid for one cycle
        smpl_rdy = 1; decim = 8'd0;
        set_ch(2'b10);
        repeat (4) strobe();
        chk("aa_word", smpl, 32'hAA);
        chk("aa_vld", smpl_vld, 1);
        @(negedge clk);
        chk("aa_vld_clr", smpl_vld, 0);

        // Sequence 00,01,10,11 -> 8'hE4
        set_ch(2'b00); strobe();
        set_ch(2'b01); strobe();
        set_ch(2'b10); strobe();
        set_ch(2'b11); strobe();
        chk("e4_word", smpl, 32'hE4);
        chk("e4_vld", smpl_vld, 1);

        // decim=2: strobes 1,4,7,10 accepted, one word
        set_ch(2'b01);
        decim = 8'd2;
        w0 = word_cnt;
        for (int s = 1; s <= 12; s++) begin
            strobe();
            if (s == 9)  chk("dec_s9_novld", smpl_vld, 0);
            if (s == 10) chk("dec_s10_vld", smpl_vld, 1);
            if (s == 10) chk("dec_s10_word", smpl, 32'h55);
        end
        repeat (2) @(negedge clk);
        chk("dec_one_word", word_cnt - w0, 1);
        decim = 8'd0;

        // Overrun with consumer stalled
        smpl_rdy = 0;
        set_ch(2'b11);
        repeat (4) strobe();
        chk("ovr_first_word", smpl, 32'hFF);
        chk("ovr_not_yet", ovr, 0);
        set_ch(2'b00);
        repeat (4) strobe();
        chk("ovr_keep_word", smpl, 32'hFF);
        chk("ovr_keep_vld", smpl_vld, 1);
        chk("ovr_set", ovr, 1);
        @(negedge clk); clr_ovr = 1;
        @(negedge clk); clr_ovr = 0;
        chk("ovr_cleared", ovr, 0);
        // Clear coinciding with a new overrun keeps the flag
        repeat (3) strobe();
        @(negedge clk); smpl_en = 1; clr_ovr = 1;
        @(negedge clk); smpl_en = 0; clr_ovr = 0;
        chk("ovr_clr_collide", ovr, 1);
        chk("ovr_collide_word", smpl, 32'hFF);
        @(negedge clk); clr_ovr = 1;
        @(negedge clk); clr_ovr = 0; smpl_rdy = 1;
        @(negedge clk);
        chk("ovr_drain_vld", smpl_vld, 0);
        chk("ovr_drain_ovr", ovr, 0);

        // Trigger edges on channel 0, then channel 1
        trig_en = 1; trig_sel = 1'b0; trig_pol = 1;
        set_ch(2'b01); strobe();
        chk("trig_rise", trig, 1);
        @(negedge clk);
        chk("trig_one_cycle", trig, 0);
        set_ch(2'b00); strobe();
        chk("trig_fall_pol1", trig, 0);
        trig_pol = 0;
        set_ch(2'b01); strobe();
        chk("trig_rise_pol0", trig, 0);
        set_ch(2'b00); strobe();
        chk("trig_fall_pol0", trig, 1);
        trig_en = 0; trig_pol = 1;
        set_ch(2'b01); strobe();
        chk("trig_disabled", trig, 0);
        trig_en = 1; trig_sel = 1'b1;
        set_ch(2'b11); strobe();
        chk("trig_ch1_rise", trig, 1);

        // Reset mid-word
        set_ch(2'b10);
        repeat (2) strobe();
        @(negedge clk); rst_n = 0;
        @(negedge clk);
        chk("mid_rst_sync", ch_sync, 0);
        chk("mid_rst_smpl", smpl, 0);
        chk("mid_rst_vld", smpl_vld, 0);
        chk("mid_rst_trig", trig, 0);
        chk("mid_rst_ovr", ovr, 0);
        rst_n = 1;
        repeat (SYNC + 1) @(negedge clk);
        for (int s = 1; s <= 4; s++) begin
            strobe();
            if (s == 1) chk("first_no_trig", trig, 0);
            if (s < 4)  chk("post_rst_novld", smpl_vld, 0);
        end
        chk("post_rst_vld", smpl_vld, 1);
        chk("post_rst_word", smpl, 32'hAA);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
